cla_sweep_checker: RTL and testbench

Sequential self-check engine sitting on the operand side of the decomposed carry-lookahead adder: it drives `a`, `b`, `c_in` into an adder instance through every one of the 2^(2·NBIT+1) input combinations and samples the adder's `s` result. It compares each result against a behavioural `a+b+c_in`, counts mismatches and captures the first failing vector. It is the stimulus/response counterpart used for sign-off and fault-injection runs of the adder. The adder itself is instantiated beside it, not inside it.

---
 rtl/cla_sweep_checker_pkg.sv | 7 +
 rtl/sweep_expect_pipe.sv | 31 +++
 rtl/cla_sweep_checker.sv | 102 ++++++++++
 tb/tb_cla_sweep_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cla_sweep_checker_pkg.sv
// cla_sweep_checker_pkg: shared adder constants (default width, latency, counter width) and sweep FSM states
package cla_sweep_checker_pkg;
  localparam int CLA_NBIT = 7;
  localparam int CLA_LAT = 0;
  localparam int CLA_ECW = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/sweep_expect_pipe.sv
// sweep_expect_pipe: reference a+b+c_in sum (exp_o) and its valid flag (vld_o), delayed LAT cycles, bypassed when LAT=0
module sweep_expect_pipe
  import cla_sweep_checker_pkg::*;
#(
  parameter int NBIT = CLA_NBIT,
  parameter int LAT = CLA_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            vld_i,
  input  logic [NBIT-1:0] a_i,
  input  logic [NBIT-1:0] b_i,
  input  logic            c_in_i,
  output logic [NBIT:0]   exp_o,
  output logic            vld_o
);
  localparam int D = LAT > 0 ? LAT : 1;
  logic [NBIT:0] sum;
  logic [NBIT:0] exp_q [D];
  logic [D-1:0]  vld_q;
  assign sum = {1'b0, a_i} + {1'b0, b_i} + {{NBIT{1'b0}}, c_in_i};
  assign exp_o = LAT == 0 ? sum : exp_q[D-1];
  assign vld_o = LAT == 0 ? vld_i : vld_q[D-1];
  always_ff @(posedge clk) begin
    exp_q[0] <= sum;
    for (int i = 1; i < D; i++) exp_q[i] <= exp_q[i-1];
  end
  always_ff @(posedge clk)
    vld_q <= rst || clr_i ? '0 : D'({vld_q, vld_i});
endmodule

// File: rtl/cla_sweep_checker.sv
// cla_sweep_checker: drives every {c_in,b,a} vector into an adder, checks s_i against a+b+c_in, counts errors and captures the first failure
module cla_sweep_checker
  import cla_sweep_checker_pkg::*;
#(
  parameter int NBIT = CLA_NBIT,
  parameter int LAT = CLA_LAT,
  parameter int ECW = CLA_ECW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [NBIT-1:0] a_o,
  output logic [NBIT-1:0] b_o,
  output logic            c_in_o,
  input  logic [NBIT:0]   s_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [ECW-1:0]  err_cnt_o,
  output logic [2*NBIT:0] fail_vec_o,
  output logic [NBIT:0]   fail_s_o
);
  localparam int VW = 2 * NBIT + 1;
  localparam int DW = LAT > 0 ? $clog2(LAT + 1) : 1;
  state_e state_q, state_d;
  logic [VW-1:0] v_q, v_d, fv_q, fv_d;
  logic [NBIT:0] fs_q, fs_d, exp_s;
  logic [ECW-1:0] err_q, err_d;
  logic [DW-1:0] drn_q, drn_d;
  logic start_q, start_d, pass_q, pass_d, exp_vld, active, last, hit;
  assign {c_in_o, b_o, a_o} = v_q;
  assign active = state_q == RUN || state_q == DRAIN;
  assign last = &v_q;
  assign hit = active && !abort_i && exp_vld && s_i != exp_s;
  assign busy_o = active;
  assign done_o = state_q == DONE;
  assign pass_o = pass_q;
  assign err_cnt_o = err_q;
  assign fail_vec_o = fv_q;
  assign fail_s_o = fs_q;
  sweep_expect_pipe #(.NBIT(NBIT), .LAT(LAT)) u_exp (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_q),
    .vld_i  (state_q == RUN),
    .a_i    (a_o),
    .b_i    (b_o),
    .c_in_i (c_in_o),
    .exp_o  (exp_s),
    .vld_o  (exp_vld)
  );
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    drn_d = drn_q;
    start_d = start_i && !abort_i && !active;
    err_d = hit && !(&err_q) ? err_q + 1'b1 : err_q;
    fv_d = hit && err_q == '0 ? v_q : fv_q;
    fs_d = hit && err_q == '0 ? s_i : fs_q;
    pass_d = pass_q;
    if (start_q) begin
      state_d = RUN;
      v_d = '0;
      err_d = '0;
      fv_d = '0;
      fs_d = '0;
      pass_d = 1'b0;
    end else if (active && abort_i) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      v_d = last ? v_q : v_q + 1'b1;
      drn_d = '0;
      state_d = last ? (LAT > 0 ? DRAIN : DONE) : RUN;
    end else if (state_q == DRAIN) begin
      drn_d = drn_q + 1'b1;
      state_d = drn_q == DW'(LAT - 1) ? DONE : DRAIN;
    end
    if (state_d == DONE && state_q != DONE) pass_d = err_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q <= '0;
      fv_q <= '0;
      fs_q <= '0;
      err_q <= '0;
      drn_q <= '0;
      start_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      fv_q <= fv_d;
      fs_q <= fs_d;
      err_q <= err_d;
      drn_q <= drn_d;
      start_q <= start_d;
      pass_q <= pass_d;
    end
  end
endmodule

// File: tb/tb_cla_sweep_checker.sv
// tb_cla_sweep_checker: NBIT=2 sweeps against good, stuck-at and pipelined adders, checked by a cycle model plus literal expectations
module tb_cla_sweep_checker;
  logic clk = 0, rst = 1, start = 0, abort = 0, mode = 0;
  int cyc = 0, npass = 0, ntot = 0, t0, tx;
  logic [1:0] a [4], b [4];
  logic c [4], busy [4], done [4], pass [4];
  logic [2:0] s [4], fs [4], p [3], q [3], err3;
  logic [4:0] fv [4];
  logic [15:0] err [3];
  logic m_busy, m_done, m_pass, m_pend;
  logic [4:0] m_vec, m_fv;
  logic [2:0] m_fs;
  int m_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] add(input logic [1:0] x, input logic [1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {2'b0, ci};
  endfunction

  assign s[0] = mode ? add(a[0], b[0], c[0]) & 3'b110 : add(a[0], b[0], c[0]);
  assign s[1] = q[1];
  assign s[2] = q[2];
  assign s[3] = add(a[3], b[3], c[3]) & 3'b110;
  always @(posedge clk)
    for (int i = 1; i < 3; i++) begin
      p[i] <= rst ? 3'b0 : add(a[i], b[i], c[i]);
      q[i] <= rst ? 3'b0 : p[i];
    end

  cla_sweep_checker #(.NBIT(2), .LAT(0), .ECW(16)) u0 (.clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .a_o(a[0]), .b_o(b[0]), .c_in_o(c[0]), .s_i(s[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .err_cnt_o(err[0]), .fail_vec_o(fv[0]), .fail_s_o(fs[0]));
  cla_sweep_checker #(.NBIT(2), .LAT(1), .ECW(16)) u1 (.clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .a_o(a[1]), .b_o(b[1]), .c_in_o(c[1]), .s_i(s[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .err_cnt_o(err[1]), .fail_vec_o(fv[1]), .fail_s_o(fs[1]));
  cla_sweep_checker #(.NBIT(2), .LAT(2), .ECW(16)) u2 (.clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .a_o(a[2]), .b_o(b[2]), .c_in_o(c[2]), .s_i(s[2]), .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]),
    .err_cnt_o(err[2]), .fail_vec_o(fv[2]), .fail_s_o(fs[2]));
  cla_sweep_checker #(.NBIT(2), .LAT(0), .ECW(3)) u3 (.clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .a_o(a[3]), .b_o(b[3]), .c_in_o(c[3]), .s_i(s[3]), .busy_o(busy[3]), .done_o(done[3]), .pass_o(pass[3]),
    .err_cnt_o(err3), .fail_vec_o(fv[3]), .fail_s_o(fs[3]));

  function automatic int true_sum(input logic [4:0] v);
    int t;
    t = v[1:0] + v[3:2] + v[4];
    return t;
  endfunction

  function automatic int adder_s(input logic [4:0] v);
    return mode ? true_sum(v) & 6 : true_sum(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_pass <= 0; m_pend <= 0;
      m_vec <= 0; m_fv <= 0; m_fs <= 0; m_err <= 0;
    end else begin
      m_pend <= start && !abort && !m_busy;
      if (m_busy && abort) m_busy <= 0;
      else if (m_busy) begin
        if (adder_s(m_vec) != true_sum(m_vec)) begin
          m_err <= m_err + 1;
          if (m_err == 0) begin m_fv <= m_vec; m_fs <= 3'(adder_s(m_vec)); end
        end
        if (m_vec == 5'd31) begin
          m_busy <= 0; m_done <= 1;
          m_pass <= m_err == 0 && adder_s(m_vec) == true_sum(m_vec);
        end else m_vec <= m_vec + 1;
      end else if (m_pend) begin
        m_busy <= 1; m_done <= 0; m_pass <= 0; m_vec <= 0; m_err <= 0; m_fv <= 0; m_fs <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk)
    if (cyc > 0) begin
      chk("model_busy", busy[0], m_busy);
      chk("model_done", done[0], m_done);
      chk("model_vec", {c[0], b[0], a[0]}, m_vec);
      chk("model_err", err[0], m_err);
      chk("model_pass", pass[0], m_pass);
      chk("model_fail_vec", fv[0], m_fv);
      chk("model_fail_s", fs[0], m_fs);
    end

  task automatic check_reset();
    chk("rst_vec", {c[0], b[0], a[0]}, 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_fail_vec", fv[0], 0);
    chk("rst_fail_s", fs[0], 0);
  endtask

  task automatic pulse_start(output int t);
    start = 1;
    @(posedge clk);
    #1 t = cyc;
    start = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int w, input int t, input int dt);
    int k = 0;
    while (!done[w] && k < 200) begin @(negedge clk); k++; end
    chk($sformatf("done_time_u%0d", w), cyc - t, dt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    @(negedge clk);
    pulse_start(t0);
    wait_done(0, t0, 33);
    chk("good_err", err[0], 0);
    chk("good_pass", pass[0], 1);
    chk("good_fail_vec", fv[0], 0);
    chk("sat_done", done[3], 1);
    chk("sat_err", err3, 7);
    chk("sat_fail_vec", fv[3], 5'b00001);
    chk("sat_pass", pass[3], 0);
    wait_done(1, t0, 34);
    chk("lat1_err_nonzero", err[1] != 0, 1);
    chk("lat1_pass", pass[1], 0);
    wait_done(2, t0, 35);
    chk("lat2_err", err[2], 0);
    chk("lat2_pass", pass[2], 1);
    mode = 1;
    pulse_start(t0);
    wait_done(0, t0, 33);
    chk("stuck_err", err[0], 16);
    chk("stuck_fail_vec", fv[0], 5'b00001);
    chk("stuck_fail_s", fs[0], 3'b000);
    chk("stuck_pass", pass[0], 0);
    mode = 0;
    pulse_start(t0);
    repeat (5) @(negedge clk);
    pulse_start(tx);
    wait_done(0, t0, 33);
    chk("restart_ignored_pass", pass[0], 1);
    pulse_start(t0);
    for (int k = 0; k < 100 && {c[0], b[0], a[0]} != 5'd10; k++) @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_vec_held", {c[0], b[0], a[0]}, 10);
    start = 1; abort = 1;
    @(posedge clk);
    #1 start = 0; abort = 0;
    repeat (3) @(negedge clk);
    chk("idle_start_abort_busy", busy[0], 0);
    pulse_start(t0);
    repeat (4) @(negedge clk);
    start = 1; abort = 1;
    @(posedge clk);
    #1 start = 0; abort = 0;
    @(negedge clk);
    chk("run_start_abort_busy", busy[0], 0);
    chk("run_start_abort_done", done[0], 0);
    pulse_start(t0);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset();
    rst = 0;
    @(negedge clk);
    pulse_start(t0);
    wait_done(0, t0, 33);
    chk("post_rst_err", err[0], 0);
    chk("post_rst_pass", pass[0], 1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
